// File: rtl/fetch_unit.sv
// Instruction-fetch stage: next-PC selection, credit-limited instruction
// memory requests, and a small response FIFO presented to decode.
module fetch_unit #(
  parameter int unsigned IMEM_BYTES = 64,
  parameter int unsigned DEPTH      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pc_out,
  output logic [15:0] pc_in,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_target,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [15:0] id_instr,
  output logic [15:0] id_pc
);

  localparam int unsigned PC_W   = 16;
  localparam int unsigned ENT_W  = 2 * PC_W;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned OCC_W  = CNT_W + 1;
  localparam logic [PC_W-1:0] PC_MASK    = PC_W'(IMEM_BYTES - 1);
  localparam logic [PC_W-1:0] ALIGN_MASK = PC_MASK & 16'hFFFE;

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             req_valid_q;
  logic [PC_W-1:0]  req_pc_q;
  logic [PC_W-1:0]  head_pc_q, head_pc_d;
  logic [PC_W-1:0]  head_instr_q, head_instr_d;
  logic [ENT_W-1:0] mem_q [DEPTH];

  logic             pop;
  logic             push;
  logic             issue;
  logic [OCC_W-1:0] occ;
  logic [CNT_W-1:0] cnt_after_pop;
  logic [ENT_W-1:0] resp;
  logic [ENT_W-1:0] next_head;

  assign imem_addr = pc_out;
  assign id_valid  = (count_q != '0);
  assign id_pc     = head_pc_q;
  assign id_instr  = head_instr_q;

  // Handshake, credit check and FIFO bookkeeping for this cycle.
  always_comb begin
    pop           = id_valid & id_ready;
    push          = req_valid_q & ~redirect_valid;
    resp          = {req_pc_q, imem_rdata};
    occ           = OCC_W'(count_q) + OCC_W'(req_valid_q) - OCC_W'(pop);
    issue         = ~redirect_valid & (occ < OCC_W'(DEPTH));
    cnt_after_pop = count_q - CNT_W'(pop);
    rd_ptr_d      = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d      = wr_ptr_q + PTR_W'(push);
    count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
    next_head     = mem_q[rd_ptr_d];
    head_pc_d     = head_pc_q;
    head_instr_d  = head_instr_q;
    if (redirect_valid) begin
      // Flush wins over any push/pop; head registers keep their last values.
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else if (cnt_after_pop != '0) begin
      head_pc_d    = next_head[ENT_W-1:PC_W];
      head_instr_d = next_head[PC_W-1:0];
    end else if (push) begin
      // Empty FIFO: the arriving response becomes the head directly.
      head_pc_d    = req_pc_q;
      head_instr_d = imem_rdata;
    end
  end

  // Next-PC select: redirect, then sequential advance, else hold.
  always_comb begin
    pc_in = pc_out;
    if (redirect_valid) begin
      pc_in = redirect_target & ALIGN_MASK;
    end else if (issue) begin
      pc_in = (pc_out + 16'd2) & PC_MASK;
    end
  end

  // Control state, request tracking and head registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      req_valid_q  <= 1'b0;
      req_pc_q     <= '0;
      head_pc_q    <= '0;
      head_instr_q <= '0;
    end else begin
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      req_valid_q  <= issue;
      req_pc_q     <= pc_out;
      head_pc_q    <= head_pc_d;
      head_instr_q <= head_instr_d;
    end
  end

  // FIFO storage; contents are only meaningful below count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= resp;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a PC register and synchronous imem model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc_out;
  logic [15:0] pc_in;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic        id_ready;
  logic        id_valid;
  logic [15:0] id_instr;
  logic [15:0] id_pc;

  logic [15:0] exp_q [$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  // PC register clearing to 0 on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_out <= 16'h0000;
    else       pc_out <= pc_in;
  end

  // Synchronous-read instruction memory: word at addr is 0x1000 + addr.
  always_ff @(posedge clk) begin
    imem_rdata <= 16'h1000 + imem_addr;
  end

  fetch_unit #(.IMEM_BYTES(64), .DEPTH(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .pc_out          (pc_out),
    .pc_in           (pc_in),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_ready        (id_ready),
    .id_valid        (id_valid),
    .id_instr        (id_instr),
    .id_pc           (id_pc)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  // Expected fetch stream from a start address, wrapping in 64 bytes.
  function automatic void refill(input logic [15:0] start);
    logic [15:0] a;
    exp_q.delete();
    a = start;
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back(a);
      a = (a + 16'd2) & 16'h003E;
    end
  endfunction

  // One cycle: drive inputs at negedge, then score any handshake.
  task automatic cyc(input logic rdy, input logic rv, input logic [15:0] tgt);
    logic [15:0] e;
    @(negedge clk);
    id_ready        = rdy;
    redirect_valid  = rv;
    redirect_target = tgt;
    #1;
    if (id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $error("FAIL sb_empty: observed id_pc 0x%04h expected no output", id_pc);
      end else begin
        e = exp_q.pop_front();
        chk("id_pc", id_pc, e);
        chk("id_instr", id_instr, 16'h1000 + e);
      end
    end
    if (rv) refill(tgt & 16'h003E);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish by 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset           = 1'b1;
    id_ready        = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 16'(id_valid), 16'h0000);
    chk("rst_instr", id_instr, 16'h0000);
    chk("rst_pc", id_pc, 16'h0000);

    // Reset release and first-fetch latency.
    refill(16'h0000);
    @(negedge clk);
    reset    = 1'b0;
    id_ready = 1'b1;
    #1;
    chk("c0_valid", 16'(id_valid), 16'h0000);
    chk("c0_pc_in", pc_in, 16'h0002);
    cyc(1'b1, 1'b0, 16'h0000);
    chk("c1_valid", 16'(id_valid), 16'h0000);
    cyc(1'b1, 1'b0, 16'h0000);
    chk("c2_valid", 16'(id_valid), 16'h0001);
    chk("c2_pc", id_pc, 16'h0000);

    // Stream up to the wrap point, then across it with no bubble.
    for (int k = 0; k < 100 && pc_out != 16'h003E; k++) cyc(1'b1, 1'b0, 16'h0000);
    chk("wrap_reach", pc_out, 16'h003E);
    chk("wrap_pc_in", pc_in, 16'h0000);
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 1'b0, 16'h0000);
      chk("stream_valid", 16'(id_valid), 16'h0001);
    end

    // Decode stall: head stable, FIFO saturates, PC holds.
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b0, 16'h0000);
      chk("stall_head", id_pc, exp_q[0]);
    end
    chk("stall_valid", 16'(id_valid), 16'h0001);
    chk("stall_hold", pc_in, pc_out);
    chk("stall_count", 16'(dut.count_q), 16'h0002);

    // Redirect with a full FIFO.
    cyc(1'b0, 1'b1, 16'h0013);
    chk("redir_pc_in", pc_in, 16'h0012);
    cyc(1'b1, 1'b0, 16'h0000);
    chk("redir_v1", 16'(id_valid), 16'h0000);
    cyc(1'b1, 1'b0, 16'h0000);
    chk("redir_v2", 16'(id_valid), 16'h0000);
    cyc(1'b1, 1'b0, 16'h0000);
    chk("redir_v3", 16'(id_valid), 16'h0001);
    chk("redir_first_pc", id_pc, 16'h0012);
    repeat (4) cyc(1'b1, 1'b0, 16'h0000);

    // Redirect and pop together with a full FIFO: flush wins.
    repeat (3) cyc(1'b0, 1'b0, 16'h0000);
    chk("full_count", 16'(dut.count_q), 16'h0002);
    cyc(1'b1, 1'b1, 16'h0020);
    chk("rp_pc_in", pc_in, 16'h0020);
    cyc(1'b1, 1'b0, 16'h0000);
    chk("rp_valid", 16'(id_valid), 16'h0000);
    chk("rp_count", 16'(dut.count_q), 16'h0000);
    cyc(1'b1, 1'b0, 16'h0000);
    cyc(1'b1, 1'b0, 16'h0000);
    chk("rp_first_pc", id_pc, 16'h0020);
    repeat (4) cyc(1'b1, 1'b0, 16'h0000);

    // Asynchronous reset mid-stream.
    chk("pre_rst_valid", 16'(id_valid), 16'h0001);
    chk("pre_rst_req", 16'(dut.req_valid_q), 16'h0001);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 16'(id_valid), 16'h0000);
    chk("arst_instr", id_instr, 16'h0000);
    chk("arst_pc", id_pc, 16'h0000);
    refill(16'h0000);
    @(negedge clk);
    reset    = 1'b0;
    id_ready = 1'b1;
    #1;
    chk("rs_c0_valid", 16'(id_valid), 16'h0000);
    cyc(1'b1, 1'b0, 16'h0000);
    chk("rs_c1_valid", 16'(id_valid), 16'h0000);
    cyc(1'b1, 1'b0, 16'h0000);
    chk("rs_c2_valid", 16'(id_valid), 16'h0001);
    chk("rs_c2_pc", id_pc, 16'h0000);
    repeat (4) cyc(1'b1, 1'b0, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
